// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the Kogge-Stone adder pipeline.
package ksa_pkg;

    // Propagate/generate pair carried through every prefix level.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Number of prefix levels needed for a carry to span the full word.
    function automatic int nlvl(input int width);
        return clog2(width);
    endfunction

endpackage

// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for ksa_pipe; master drives operands, slave is the adder.
interface ksa_pipe_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level (combine distance DIST) with an optional stage register.
module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DIST  = 1,
    parameter bit REG   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 vld,
    input  pg_t  [WIDTH-1:0]     pg,
    input  logic [WIDTH+1:0]     side,
    output logic                 vld_q,
    output pg_t  [WIDTH-1:0]     pg_q,
    output logic [WIDTH+1:0]     side_q
);
    pg_t [WIDTH-1:0] pg_d;

    // Positions below 2*DIST already span bit 0 after this level, so their P is dead (grey cell).
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i >= 2 * DIST) begin : g_black
            assign pg_d[i].g = pg[i].g | (pg[i].p & pg[i-DIST].g);
            assign pg_d[i].p = pg[i].p & pg[i-DIST].p;
        end else if (i >= DIST) begin : g_grey
            assign pg_d[i].g = pg[i].g | (pg[i].p & pg[i-DIST].g);
            assign pg_d[i].p = pg[i].p;
        end else begin : g_buf
            assign pg_d[i] = pg[i];
        end
    end

    if (REG) begin : g_reg
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  vld_q <= 1'b0;
            else if (en) vld_q <= vld;
        end

        // NOTE: datapath flops have no reset; the valid bit alone says whether their contents matter.
        always_ff @(posedge clk) begin
            if (en) begin
                pg_q   <= pg_d;
                side_q <= side;
            end
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, en};
        assign vld_q      = vld;
        assign pg_q       = pg_d;
        assign side_q     = side;
    end
endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a global stall.
module ksa_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter bit PIPE  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    ksa_pipe_if.slave     bus
);
    localparam int NLVL = nlvl(WIDTH);
    localparam int SW   = WIDTH + 2;

    logic             en;
    logic [WIDTH-1:0] bx;
    logic             c0;
    pg_t  [WIDTH-1:0] pg0;
    logic [SW-1:0]    side0;

    logic             s0_vld;
    pg_t  [WIDTH-1:0] s0_pg;
    logic [SW-1:0]    s0_side;

    logic             lvl_vld  [NLVL+1];
    pg_t  [WIDTH-1:0] lvl_pg   [NLVL+1];
    logic [SW-1:0]    lvl_side [NLVL+1];

    // One enable for the whole pipe: it only moves when the output slot can drain.
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // NOTE: every always_comb output is fully assigned on every path, so no latch is inferred.
    always_comb begin
        bx = bus.sub ? ~bus.b : bus.b;
        c0 = bus.sub | bus.cin;
        for (int i = 0; i < WIDTH; i++) begin
            pg0[i].p = bus.a[i] ^ bx[i];
            pg0[i].g = bus.a[i] & bx[i];
        end
        // Fold the carry-in into bit 0 so the prefix output is the carry out of each bit.
        pg0[0].g = pg0[0].g | (pg0[0].p & c0);
        side0    = {bus.a[WIDTH-1], c0, bus.a ^ bx};
    end

    if (PIPE) begin : g_s0_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  s0_vld <= 1'b0;
            else if (en) s0_vld <= bus.in_valid;
        end

        always_ff @(posedge clk) begin
            if (en) begin
                s0_pg   <= pg0;
                s0_side <= side0;
            end
        end
    end else begin : g_s0_comb
        assign s0_vld  = bus.in_valid;
        assign s0_pg   = pg0;
        assign s0_side = side0;
    end

    assign lvl_vld[0]  = s0_vld;
    assign lvl_pg[0]   = s0_pg;
    assign lvl_side[0] = s0_side;

    // The last level feeds the sum register directly, keeping latency at NLVL+1.
    for (genvar k = 0; k < NLVL; k++) begin : g_lvl
        ksa_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .REG   (PIPE && (k < NLVL - 1))
        ) u_lvl (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .vld    (lvl_vld[k]),
            .pg     (lvl_pg[k]),
            .side   (lvl_side[k]),
            .vld_q  (lvl_vld[k+1]),
            .pg_q   (lvl_pg[k+1]),
            .side_q (lvl_side[k+1])
        );
    end

    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] p_fin;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             a_msb;
    logic             c_in;
    logic             unused_p;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            g_fin[i] = lvl_pg[NLVL][i].g;
            p_fin[i] = lvl_pg[NLVL][i].p;
        end
        {a_msb, c_in, p_bit} = lvl_side[NLVL];
        carry[0] = c_in;
        for (int i = 1; i < WIDTH; i++) carry[i] = g_fin[i-1];
        sum_d = p_bit ^ carry;
    end

    assign unused_p = ^p_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else if (en) begin
            bus.out_valid <= lvl_vld[NLVL];
            if (lvl_vld[NLVL]) begin
                bus.sum  <= sum_d;
                bus.cout <= g_fin[WIDTH-1];
                // Operand signs agree exactly when the MSB propagate is 0.
                bus.ovf  <= !p_bit[WIDTH-1] && (sum_d[WIDTH-1] != a_msb);
            end
        end
    end
endmodule

// File: doc/ksa_pipe.md
KSA_PIPE -- requirements
Module: ksa_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning operand/sum width; legal range 4..64.
REQ-002 SHALL have parameter PIPE, default 1, meaning 1 = register after every prefix level, 0 = combinational prefix with output register only.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 SHALL have port a, input, WIDTH, first operand.
REQ-008 SHALL have port b, input, WIDTH, second operand.
REQ-009 SHALL have port cin, input, 1, carry-in (add mode only).
REQ-010 SHALL have port sub, input, 1, 0 = add, 1 = subtract a-b.
REQ-011 SHALL have port out_valid, output, 1, result beat present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port sum, output, WIDTH, result.
REQ-014 SHALL have port cout, output, 1, carry-out (add) / no-borrow (sub).
REQ-015 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-016 SHALL compute, per accepted beat, sum/cout = a + b + cin when sub=0, and a + ~b + 1 when sub=1 (cin ignored).
REQ-017 SHALL set ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is b or ~b per sub.
REQ-018 SHALL implement carries with a Kogge-Stone parallel prefix of NLVL = ceil(log2(WIDTH)) levels (5 for WIDTH=24), pairing distance 2^k at level k.
REQ-019 SHALL register propagate/generate/operands on accept (stage 0); with PIPE=1, one register after each prefix level plus sum register; latency accept-to-out_valid = NLVL+1 cycles (6 at WIDTH=24); with PIPE=0, latency = 1.
REQ-020 SHALL accept a beat when in_valid && in_ready; throughput one beat per cycle absent back-pressure.
REQ-021 SHALL drive in_ready = !out_valid || out_ready (global pipeline enable); when deasserted every stage register, including valid bits, holds.
REQ-022 SHALL hold sum, cout, ovf, out_valid stable while out_valid && !out_ready.
REQ-023 SHALL carry a valid bit per stage so bubbles propagate; out_valid asserts only for accepted beats, in order, none lost or duplicated.
REQ-024 SHALL ignore a, b, cin, sub when no beat is accepted.
REQ-025 SHALL wrap modulo 2^WIDTH: all-ones + 1 gives sum 0, cout 1.

Reset
REQ-026 SHALL, on rst_n low, immediately clear all valid bits and drive out_valid=0, sum=0, cout=0, ovf=0; in_ready reads 1 during reset.
REQ-027 SHALL discard all in-flight beats on reset mid-operation; first accept after rst_n rises produces the first out_valid exactly latency cycles later.

Structure
REQ-028 SHALL place the clog2 function, NLVL derivation and the pg-pair typedef in shared package ksa_pkg.
REQ-029 SHALL instantiate one sub-module ksa_prefix_level per level (parameters WIDTH, DIST, REG) containing black/grey cells and the optional stage register.

Verification
REQ-030 SHALL cover: WIDTH=24, PIPE=1, a=0xFFFFFF, b=0x000000, cin=1, sub=0 -> 6 cycles later sum=0x000000, cout=1, ovf=0.
REQ-031 SHALL cover: a=0x7FFFFF, b=0x000001, sub=0 -> sum=0x800000, cout=0, ovf=1; a=0x000005, b=0x000007, sub=1 -> sum=0xFFFFFE, cout=0, ovf=0.
REQ-032 SHALL cover: 100 back-to-back random beats, out_ready=1 -> 100 results in order, one per cycle after 6-cycle fill, all matching reference model.
REQ-033 SHALL cover: out_ready held 0 for 10 cycles with pipeline full -> in_ready=0, sum/out_valid stable, no beat lost when out_ready returns to 1.
REQ-034 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, those beats never emerge; next beat returns after 6 cycles.
REQ-035 SHALL cover: PIPE=0 and WIDTH=8/64 builds -> latency 1 (PIPE=0), random self-check passes for each width.
